// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Constants shared by the UART host link: the command and
//                response byte codes, the bit period at 16.368 MHz / 115200
//                baud, and the state encoding of the register responder.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Host command bytes ('W' and 'R') and single-byte responses
    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    // clk cycles per UART bit
    localparam int CLKS_PER_BIT = 142;

    // Register responder FSM encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_GET_ADDR = 3'd1;
    localparam logic [2:0] ST_GET_DATA = 3'd2;
    localparam logic [2:0] ST_DO_WR    = 3'd3;
    localparam logic [2:0] ST_DO_RD    = 3'd4;
    localparam logic [2:0] ST_CAP_RD   = 3'd5;
    localparam logic [2:0] ST_SEND     = 3'd6;
    localparam logic [2:0] ST_WAIT_TX  = 3'd7;

endpackage
`default_nettype wire

// File: rtl/uart_frame_timeout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_frame_timeout
//  Description : Inter-byte gap counter. Counts while i_run is high, returns
//                to zero on i_clr or whenever it is not running, and flags
//                o_expire while the count sits at TIMEOUT_CLKS-1.
//  Ports       : i_clk     clock
//                i_rst_n   synchronous active-low reset
//                i_run     count enable (counter held at 0 when low)
//                i_clr     restart the count from 0 on the next cycle
//                o_expire  high on the TIMEOUT_CLKS-th running cycle
//  Revision    : 1.0  initial release
// ============================================================================
module uart_frame_timeout #(
    parameter int TIMEOUT_CLKS = 2840
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_clr,
    output logic o_expire
);

    localparam int c_cnt_w = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT_CLKS - 1);

    logic [c_cnt_w-1:0] r_count_q;
    logic [c_cnt_w-1:0] w_count_d;

    // Saturate at the last value so a caller that ignores the expiry does
    // not see the flag wrap around and re-fire.
    always_comb begin
        w_count_d = r_count_q;
        if (i_clr || !i_run) begin
            w_count_d = '0;
        end else if (r_count_q != c_last) begin
            w_count_d = r_count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign o_expire = i_run && (r_count_q == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_reg_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_reg_responder
//  Description : Device-side end of the host UART link. Parses 'W' addr data
//                and 'R' addr frames from uart_rx, issues register write/read
//                strobes, and answers every frame with one byte via uart_tx
//                (ACK, read data, or NAK). Frames stalled between bytes for
//                TIMEOUT_CLKS cycles are aborted silently.
//  Ports       : clk_in, rst_in_n        clock, synchronous active-low reset
//                rx_dv_in, rx_data_in    received byte strobe and value
//                tx_active_in, tx_done_in  uart_tx busy / done pulse
//                tx_dv_out, tx_data_out  transmit start pulse and byte
//                reg_wr_out, reg_rd_out  register strobes (1 cycle)
//                reg_addr_out, reg_wdata_out  address and write data
//                reg_rdata_in            read data, valid 1 cycle after read
//                frame_err_out           pulse on NAK or timeout abort
//  Revision    : 1.0  initial release
// ============================================================================
module uart_reg_responder #(
    parameter int         ADDR_W       = 4,
    parameter int         TIMEOUT_CLKS = 2840,
    parameter logic [7:0] CMD_WR       = uart_pkg::CMD_WR,
    parameter logic [7:0] CMD_RD       = uart_pkg::CMD_RD,
    parameter logic [7:0] RSP_ACK      = uart_pkg::RSP_ACK,
    parameter logic [7:0] RSP_NAK      = uart_pkg::RSP_NAK
) (
    input  logic              clk_in,
    input  logic              rst_in_n,
    input  logic              rx_dv_in,
    input  logic [7:0]        rx_data_in,
    input  logic              tx_active_in,
    input  logic              tx_done_in,
    output logic              tx_dv_out,
    output logic [7:0]        tx_data_out,
    output logic              reg_wr_out,
    output logic              reg_rd_out,
    output logic [ADDR_W-1:0] reg_addr_out,
    output logic [7:0]        reg_wdata_out,
    input  logic [7:0]        reg_rdata_in,
    output logic              frame_err_out
);

    import uart_pkg::*;

    logic [2:0]        r_state_q,  w_state_d;
    logic              r_is_rd_q,  w_is_rd_d;
    logic [ADDR_W-1:0] r_addr_q,   w_addr_d;
    logic [7:0]        r_wdata_q,  w_wdata_d;
    logic [7:0]        r_rsp_q,    w_rsp_d;

    logic w_err;
    logic w_addr_ok;
    logic w_tmo_run;
    logic w_tmo_clr;
    logic w_tmo_expire;

    // Any bit above the address field makes the address invalid
    assign w_addr_ok = ((rx_data_in >> ADDR_W) == 8'd0);

    // Gap timer runs only while waiting for the rest of a frame; it restarts
    // on every byte and on every state change.
    assign w_tmo_run = (r_state_q == ST_GET_ADDR) || (r_state_q == ST_GET_DATA);
    assign w_tmo_clr = rx_dv_in || (w_state_d != r_state_q);

    uart_frame_timeout #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_timeout (
        .i_clk    (clk_in),
        .i_rst_n  (rst_in_n),
        .i_run    (w_tmo_run),
        .i_clr    (w_tmo_clr),
        .o_expire (w_tmo_expire)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_is_rd_d = r_is_rd_q;
        w_addr_d  = r_addr_q;
        w_wdata_d = r_wdata_q;
        w_rsp_d   = r_rsp_q;
        w_err     = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (rx_dv_in) begin
                    if ((rx_data_in == CMD_WR) || (rx_data_in == CMD_RD)) begin
                        w_is_rd_d = (rx_data_in == CMD_RD);
                        w_state_d = ST_GET_ADDR;
                    end else begin
                        w_rsp_d   = RSP_NAK;
                        w_err     = 1'b1;
                        w_state_d = ST_SEND;
                    end
                end
            end
            // A byte arriving on the expiry cycle takes precedence
            ST_GET_ADDR: begin
                if (rx_dv_in) begin
                    if (w_addr_ok) begin
                        w_addr_d  = rx_data_in[ADDR_W-1:0];
                        w_state_d = r_is_rd_q ? ST_DO_RD : ST_GET_DATA;
                    end else begin
                        w_rsp_d   = RSP_NAK;
                        w_err     = 1'b1;
                        w_state_d = ST_SEND;
                    end
                end else if (w_tmo_expire) begin
                    w_err     = 1'b1;
                    w_state_d = ST_IDLE;
                end
            end
            ST_GET_DATA: begin
                if (rx_dv_in) begin
                    w_wdata_d = rx_data_in;
                    w_state_d = ST_DO_WR;
                end else if (w_tmo_expire) begin
                    w_err     = 1'b1;
                    w_state_d = ST_IDLE;
                end
            end
            ST_DO_WR: begin
                w_rsp_d   = RSP_ACK;
                w_state_d = ST_SEND;
            end
            ST_DO_RD: begin
                w_state_d = ST_CAP_RD;
            end
            ST_CAP_RD: begin
                w_rsp_d   = reg_rdata_in;
                w_state_d = ST_SEND;
            end
            ST_SEND: begin
                if (!tx_active_in) begin
                    w_state_d = ST_WAIT_TX;
                end
            end
            ST_WAIT_TX: begin
                if (tx_done_in) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            r_state_q <= ST_IDLE;
            r_is_rd_q <= 1'b0;
            r_addr_q  <= '0;
            r_wdata_q <= 8'd0;
            r_rsp_q   <= 8'd0;
        end else begin
            r_state_q <= w_state_d;
            r_is_rd_q <= w_is_rd_d;
            r_addr_q  <= w_addr_d;
            r_wdata_q <= w_wdata_d;
            r_rsp_q   <= w_rsp_d;
        end
    end

    // Pulses are decoded from the state and masked while reset is held so
    // every output reads zero during reset, not only after the next edge.
    assign reg_wr_out    = rst_in_n && (r_state_q == ST_DO_WR);
    assign reg_rd_out    = rst_in_n && (r_state_q == ST_DO_RD);
    assign tx_dv_out     = rst_in_n && (r_state_q == ST_SEND) && !tx_active_in;
    assign frame_err_out = rst_in_n && w_err;
    assign tx_data_out   = r_rsp_q;
    assign reg_addr_out  = r_addr_q;
    assign reg_wdata_out = r_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_reg_responder
//  Description : Self-checking bench for uart_reg_responder. A byte-level
//                host drives frames, a register file and a uart_tx model
//                respond, and a frame-level reference model predicts the
//                response byte, strobes, errors and latencies.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_reg_responder;

    localparam int         ADDR_W = 4;
    localparam int         TMO    = 50;
    localparam logic [7:0] B_WR   = 8'h57;
    localparam logic [7:0] B_RD   = 8'h52;
    localparam logic [7:0] B_ACK  = 8'h06;
    localparam logic [7:0] B_NAK  = 8'h15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rx_dv;
    logic [7:0]        rx_data;
    logic              tx_act_m;
    logic              tx_hold;
    logic              tx_active;
    logic              tx_done;
    logic              tx_dv;
    logic [7:0]        tx_data;
    logic              reg_wr;
    logic              reg_rd;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic [7:0]        reg_rdata = 8'h00;
    logic              frame_err;

    assign tx_active = tx_act_m | tx_hold;

    always #5 clk = ~clk;

    uart_reg_responder #(
        .ADDR_W       (ADDR_W),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .clk_in        (clk),
        .rst_in_n      (rst_n),
        .rx_dv_in      (rx_dv),
        .rx_data_in    (rx_data),
        .tx_active_in  (tx_active),
        .tx_done_in    (tx_done),
        .tx_dv_out     (tx_dv),
        .tx_data_out   (tx_data),
        .reg_wr_out    (reg_wr),
        .reg_rd_out    (reg_rd),
        .reg_addr_out  (reg_addr),
        .reg_wdata_out (reg_wdata),
        .reg_rdata_in  (reg_rdata),
        .frame_err_out (frame_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- event monitor and register file (device side) -------
    int cyc = 0;
    int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, txdv_cnt = 0, done_cnt = 0;
    int rx_cyc = 0, wr_cyc = 0, rd_cyc = 0, txdv_cyc = 0, err_cyc = 0;
    logic [7:0]        last_tx = 8'h00;
    logic [ADDR_W-1:0] wr_addr_seen = '0, rd_addr_seen = '0;
    logic [7:0]        wr_data_seen = 8'h00;
    logic              rd_pend = 1'b0;
    logic [7:0]        bank [16] = '{default: 8'h00};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rd_pend <= reg_rd;
        if (rx_dv) rx_cyc <= cyc;
        if (reg_wr) begin
            wr_cnt       <= wr_cnt + 1;
            wr_cyc       <= cyc;
            wr_addr_seen <= reg_addr;
            wr_data_seen <= reg_wdata;
            bank[reg_addr] <= reg_wdata;
        end
        if (reg_rd) begin
            rd_cnt       <= rd_cnt + 1;
            rd_cyc       <= cyc;
            rd_addr_seen <= reg_addr;
        end
        if (frame_err) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (tx_dv) begin
            txdv_cnt <= txdv_cnt + 1;
            txdv_cyc <= cyc;
            last_tx  <= tx_data;
        end
        if (tx_done) done_cnt <= done_cnt + 1;
    end

    // Read data is only valid in the cycle after the read strobe; garbage
    // otherwise so an early or late capture shows up.
    always @(posedge clk) reg_rdata <= rd_pend ? bank[rd_addr_seen] : 8'($urandom);

    // ---------------- uart_tx model ----------------
    int tx_unstable = 0;
    initial begin
        logic [7:0] b;
        int n;
        tx_act_m = 1'b0;
        tx_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_dv) begin
                b = tx_data;
                @(posedge clk); #1;
                tx_act_m = 1'b1;
                n = $urandom_range(4, 10);
                repeat (n) begin
                    @(negedge clk);
                    if (tx_data !== b) tx_unstable++;
                end
                @(posedge clk); #1;
                tx_act_m = 1'b0;
                tx_done  = 1'b1;
                @(posedge clk); #1;
                tx_done  = 1'b0;
            end
        end
    end

    // ---------------- reference model state ----------------
    logic [7:0]        ref_mem [16] = '{default: 8'h00};
    logic [7:0]        mdl_wdata = 8'h00;
    logic [ADDR_W-1:0] mdl_addr  = '0;

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_dv   = 1'b1;
        rx_data = b;
        @(posedge clk); #1;
        rx_dv   = 1'b0;
        rx_data = 8'($urandom);
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic do_frame(input logic [7:0] cmd, input logic [7:0] adr, input logic [7:0] dat,
                            input int gap, input string tag);
        int nb, t;
        int s_wr, s_rd, s_err, s_tx, s_done;
        logic [7:0] rsp;
        bit ew, er, ee;
        ew = 0; er = 0; ee = 0;
        if (cmd != B_WR && cmd != B_RD) begin
            nb = 1; rsp = B_NAK; ee = 1;
        end else if (adr >= 8'd16) begin
            nb = 2; rsp = B_NAK; ee = 1;
        end else if (cmd == B_WR) begin
            nb = 3; rsp = B_ACK; ew = 1;
        end else begin
            nb = 2; rsp = ref_mem[adr[3:0]]; er = 1;
        end
        s_wr = wr_cnt; s_rd = rd_cnt; s_err = err_cnt; s_tx = txdv_cnt; s_done = done_cnt;
        send_byte(cmd, (nb > 1) ? gap : 0);
        if (nb > 1) send_byte(adr, (nb > 2) ? gap : 0);
        if (nb > 2) send_byte(dat, 0);
        t = 0;
        while (done_cnt == s_done && t < 1000) begin @(posedge clk); #1; t++; end
        check({tag, "_resp_timeout"}, 32'(t < 1000), 32'd1);
        @(posedge clk); #1;
        check({tag, "_rsp"},  32'(last_tx), 32'(rsp));
        check({tag, "_ntx"},  32'(txdv_cnt - s_tx), 32'd1);
        check({tag, "_nwr"},  32'(wr_cnt - s_wr), 32'(ew));
        check({tag, "_nrd"},  32'(rd_cnt - s_rd), 32'(er));
        check({tag, "_nerr"}, 32'(err_cnt - s_err), 32'(ee));
        if (ew) begin
            ref_mem[adr[3:0]] = dat;
            mdl_wdata = dat;
            mdl_addr  = adr[3:0];
            check({tag, "_waddr"}, 32'(wr_addr_seen), 32'(adr));
            check({tag, "_wdata"}, 32'(wr_data_seen), 32'(dat));
            check({tag, "_wlat"},  32'(wr_cyc - rx_cyc), 32'd1);
            check({tag, "_wtxlat"}, 32'(txdv_cyc - wr_cyc), 32'd1);
        end
        if (er) begin
            mdl_addr = adr[3:0];
            check({tag, "_raddr"}, 32'(rd_addr_seen), 32'(adr));
            check({tag, "_rlat"},  32'(rd_cyc - rx_cyc), 32'd1);
            check({tag, "_rtxlat"}, 32'(txdv_cyc - rd_cyc), 32'd2);
        end
        check({tag, "_addr_hold"},  32'(reg_addr), 32'(mdl_addr));
        check({tag, "_wdata_hold"}, 32'(reg_wdata), 32'(mdl_wdata));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s_wr, s_rd, s_err, s_tx, s_done, t, k, g;
        logic [7:0] b;
        logic [3:0] a, ra;

        rst_n = 1'b0; rx_dv = 1'b0; rx_data = 8'h00; tx_hold = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", 32'({tx_dv, tx_data, reg_wr, reg_rd, reg_addr, reg_wdata, frame_err}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Directed frames
        do_frame(B_WR, 8'h03, 8'hA5, 0, "wr");
        do_frame(B_RD, 8'h03, 8'h00, 0, "rd");
        do_frame(B_WR, 8'h07, 8'h3C, 2, "wr2");
        do_frame(B_RD, 8'h07, 8'h00, 1, "rd2");
        do_frame(8'h41, 8'h00, 8'h00, 0, "badcmd");
        do_frame(B_WR, 8'h10, 8'h99, 0, "badaddr");
        do_frame(B_WR, 8'h0F, 8'h5E, 0, "wr_top");

        // Timeout: silence after the address byte
        s_wr = wr_cnt; s_err = err_cnt; s_tx = txdv_cnt;
        send_byte(B_WR, 0);
        send_byte(8'h03, 0);
        repeat (TMO + 10) begin @(posedge clk); #1; end
        check("tmo_nerr", 32'(err_cnt - s_err), 32'd1);
        check("tmo_when", 32'(err_cyc - rx_cyc), 32'(TMO));
        check("tmo_ntx",  32'(txdv_cnt - s_tx), 32'd0);
        check("tmo_nwr",  32'(wr_cnt - s_wr), 32'd0);
        do_frame(B_RD, 8'h03, 8'h00, 0, "after_tmo");

        // Bytes landing on the last allowed cycle still win
        do_frame(B_WR, 8'h05, 8'h77, TMO - 1, "tmo_edge");

        // Busy TX, plus a stray byte during WAIT_TX
        tx_hold = 1'b1;
        s_tx = txdv_cnt; s_wr = wr_cnt; s_err = err_cnt; s_done = done_cnt;
        send_byte(B_WR, 0); send_byte(8'h03, 0); send_byte(8'h5A, 0);
        repeat (20) begin @(posedge clk); #1; end
        check("busy_no_txdv", 32'(txdv_cnt - s_tx), 32'd0);
        check("busy_nwr", 32'(wr_cnt - s_wr), 32'd1);
        ref_mem[3] = 8'h5A; mdl_wdata = 8'h5A; mdl_addr = 4'h3;
        tx_hold = 1'b0;
        t = 0;
        while (txdv_cnt == s_tx && t < 20) begin @(posedge clk); #1; t++; end
        check("busy_release_txdv", 32'(txdv_cnt - s_tx), 32'd1);
        check("busy_rsp", 32'(last_tx), 32'(B_ACK));
        send_byte(B_RD, 0);
        t = 0;
        while (done_cnt == s_done && t < 200) begin @(posedge clk); #1; t++; end
        repeat (3) begin @(posedge clk); #1; end
        check("busy_total_txdv", 32'(txdv_cnt - s_tx), 32'd1);
        check("busy_drop_nerr", 32'(err_cnt - s_err), 32'd0);
        do_frame(B_RD, 8'h03, 8'h00, 0, "after_drop");

        // Reset mid-frame
        s_wr = wr_cnt; s_rd = rd_cnt; s_err = err_cnt; s_tx = txdv_cnt;
        send_byte(B_WR, 0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_outs", 32'({tx_dv, tx_data, reg_wr, reg_rd, reg_addr, reg_wdata, frame_err}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mdl_wdata = 8'h00; mdl_addr = '0;
        repeat (10) begin @(posedge clk); #1; end
        check("midrst_quiet", 32'((wr_cnt - s_wr) + (rd_cnt - s_rd) + (err_cnt - s_err) + (txdv_cnt - s_tx)), 32'd0);
        do_frame(B_WR, 8'h01, 8'hFF, 0, "post_rst");

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 99);
            g = $urandom_range(0, 3);
            if (k < 5) begin
                b = 8'($urandom);
                if (b == B_WR || b == B_RD) b = 8'h41;
                do_frame(b, 8'h00, 8'h00, g, "rnd_badcmd");
            end else if (k < 10) begin
                do_frame(B_WR, 8'($urandom_range(16, 255)), 8'($urandom), g, "rnd_badaddr");
            end
            a = 4'($urandom);
            do_frame(B_WR, {4'h0, a}, 8'($urandom), g, "rnd_wr");
            ra = a;
            if ($urandom_range(0, 1) == 0) ra = 4'($urandom);
            do_frame(B_RD, {4'h0, ra}, 8'h00, g, "rnd_rd");
        end

        check("tx_data_stable", 32'(tx_unstable), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_reg_responder.md
Name: uart_reg_responder

Overview:
- Host-command responder sitting between uart_rx/uart_tx and the generator's configuration register bus.
- Consumes received bytes, parses 2- or 3-byte command frames from the host, and issues register write/read strobes.
- Answers each frame with exactly one response byte through the uart_tx byte interface.
- It is the device-side end of the host UART link (the host acts as initiator).

Parameters:
- ADDR_W, 4, register address width; a frame address >= 2**ADDR_W is invalid.
- TIMEOUT_CLKS, 2840, maximum clk_in cycles allowed between bytes of one frame; default is about 2 byte times at 142 clks/bit.
- CMD_WR, 8'h57, write command byte ('W').
- CMD_RD, 8'h52, read command byte ('R').
- RSP_ACK, 8'h06, write acknowledge byte.
- RSP_NAK, 8'h15, error response byte.

Ports:
- clk_in  input  1  system clock (16.368 MHz)
- rst_in_n  input  1  synchronous, active-low reset
- rx_dv_in  input  1  1-cycle pulse: rx_data_in valid (from uart_rx rx_dv_out)
- rx_data_in  input  8  received byte
- tx_active_in  input  1  uart_tx busy
- tx_done_in  input  1  uart_tx 1-cycle done pulse
- tx_dv_out  output  1  1-cycle pulse: start transmitting tx_data_out
- tx_data_out  output  8  response byte, held stable until tx_done_in
- reg_wr_out  output  1  1-cycle register write strobe
- reg_rd_out  output  1  1-cycle register read strobe
- reg_addr_out  output  ADDR_W  register address, valid with the strobes
- reg_wdata_out  output  8  write data, valid with reg_wr_out
- reg_rdata_in  input  8  read data, valid exactly 1 cycle after reg_rd_out
- frame_err_out  output  1  1-cycle pulse on NAK or timeout abort

Behaviour:
- Clock and reset: single clock, clk_in. Reset is synchronous, active-low, on rst_in_n.
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0.
- Reset mid-frame or mid-response: the frame is discarded and no strobe or tx_dv_out is issued after reset. A byte already in flight in uart_tx is not this block's concern.
- FSM states: IDLE, GET_ADDR, GET_DATA, DO_WR, DO_RD, CAP_RD, SEND, WAIT_TX.
- IDLE, on rx_dv_in:
  - byte==CMD_WR or CMD_RD -> latch the command, go to GET_ADDR.
  - Any other byte -> response byte = RSP_NAK, pulse frame_err_out, go to SEND.
- GET_ADDR, on rx_dv_in: latch the address.
  - Address out of range -> NAK path.
  - Otherwise, WR -> GET_DATA; RD -> DO_RD.
- GET_DATA, on rx_dv_in: latch the data, go to DO_WR.
- DO_WR: reg_wr_out=1 for one cycle; response byte = RSP_ACK; go to SEND.
- DO_RD: reg_rd_out=1 for one cycle; go to CAP_RD.
- CAP_RD: capture reg_rdata_in as the response byte; go to SEND.
- SEND: wait until tx_active_in==0, then pulse tx_dv_out for 1 cycle; go to WAIT_TX.
- WAIT_TX: on tx_done_in go to IDLE.
- Timeout:
  - The counter runs only in GET_ADDR and GET_DATA, clears on every accepted rx_dv_in, and clears on every state entry.
  - When it reaches TIMEOUT_CLKS-1 with no byte: pulse frame_err_out, go to IDLE, send no response.
- rx_dv_in arriving in DO_WR/DO_RD/CAP_RD/SEND/WAIT_TX is dropped. The host must wait for the response byte before sending the next frame.
- rx_dv_in in the same cycle as a timeout expiry: the byte wins, the frame proceeds, and no error is flagged.
- Latency:
  - Last write byte rx_dv_in to reg_wr_out: 1 cycle.
  - Address byte to reg_rd_out: 1 cycle.
  - reg_wr_out/reg_rd_out to tx_dv_out: 1 cycle (write) or 2 cycles (read), provided tx is idle.
- Invariants:
  - reg_addr_out and reg_wdata_out hold their last latched values between frames.
  - At most one strobe per frame.
  - Exactly one tx_dv_out per non-timed-out frame.

Decomposition:
- Shared package uart_pkg: CMD_WR, CMD_RD, RSP_ACK, RSP_NAK constants, the FSM state encoding, and CLKS_PER_BIT=142. The package is shared with uart_tx/uart_rx benches.
- One natural sub-module: uart_frame_timeout (load/clear counter with expiry pulse), so the same block can be reused for the rx idle-line detect.
- Top-level integration instantiates uart_rx -> uart_reg_responder -> uart_tx.

Test Plan:
- Write: bytes 57,03,A5 -> reg_wr_out 1 cycle later with addr=3, wdata=A5; tx_dv_out with 06; rx side decodes 06.
- Read: bytes 52,03 with reg_rdata_in=3C -> reg_rd_out with addr=3; response byte 3C received.
- Invalid command: byte 41 -> frame_err_out pulse, response 15, no strobe. Address 57,10 (ADDR_W=4) -> response 15, no reg_wr_out.
- Timeout: bytes 57,03, then silence > TIMEOUT_CLKS -> frame_err_out pulse, FSM in IDLE, no tx_dv_out. A following 52,03 then completes normally.
- Busy TX: hold tx_active_in=1 when the response is ready -> tx_dv_out stays 0 until tx_active_in falls, then pulses once. An extra byte sent during WAIT_TX is dropped.
- Reset: assert rst_in_n=0 after byte 57 -> all outputs 0. After release, 57,01,FF is processed as a fresh frame.
- Random loopback: 1000 random write/read pairs through uart_rx/uart_tx models at 115200 baud -> read-back equals written data, zero errors.
